// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Bytes pushed with send_enable are buffered and sent LSB first, with frames
// chained back to back while the FIFO holds data. Pushes into a full FIFO are
// dropped and latch the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send_enable,
  input  logic [7:0]                    data_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  state_t           state_q;
  logic [15:0]      baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             full_w, empty_w, baud_end_w, push_w, pop_w;

  assign full_w     = (count_q == DEPTH_C);
  assign empty_w    = (count_q == '0);
  assign baud_end_w = (baud_q == BAUD_MAX);
  // full is taken from the pre-edge occupancy, so a same-edge pop never frees a slot
  assign push_w     = send_enable & ~full_w;
  // A pop happens when leaving IDLE or at the last cycle of STOP with data waiting
  assign pop_w      = ~empty_w & ((state_q == IDLE) | ((state_q == STOP) & baud_end_w));

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (send_enable & full_w);
  end

  // Buffer storage: written only by accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Shift register: loads the head byte on a pop, shifts right after each data bit
  always_ff @(posedge clk) begin
    if (pop_w) begin
      shift_q <= mem_q[rd_ptr_q];
    end else if ((state_q == DATA) && baud_end_w && (bit_idx_q != 3'd7)) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Transmit FSM; tx is registered and set one edge ahead of each bit period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop_w) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_end_w) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_end_w) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_end_w) begin
            baud_q <= '0;
            if (pop_w) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: frame-level reference model plus a serial-line
// scoreboard that decodes every frame and compares it with the accepted bytes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, full, empty, overflow;
  logic [2:0] count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .send_enable(send_enable), .data_in(data_in),
    .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: occupancy, cycles left in the current frame, sticky flag
  int m_occ = 0;
  int m_left = 0;
  bit m_ovf = 1'b0;
  logic [7:0] exp_q [$];

  // Serial monitor state
  int mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void check_outputs();
    check("busy",     int'(busy),     int'(m_left > 0));
    check("count",    int'(count),    m_occ);
    check("full",     int'(full),     int'(m_occ == DEPTH));
    check("empty",    int'(empty),    int'(m_occ == 0));
    check("overflow", int'(overflow), int'(m_ovf));
  endfunction

  // Model of one rising edge: a frame occupies FRAME cycles; the transmitter
  // takes the next byte when idle or at the end of a frame; fullness is judged
  // on the occupancy before the edge.
  function automatic void model_edge(logic se, logic [7:0] d);
    bit full_pre;
    bit pop;
    full_pre = (m_occ == DEPTH);
    pop = 1'b0;
    if (m_left == 0 || m_left == 1) begin
      if (m_occ > 0) begin
        pop = 1'b1;
        m_left = FRAME;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
    end
    if (pop) m_occ--;
    if (se) begin
      if (!full_pre) begin
        m_occ++;
        exp_q.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  // Scoreboard monitor: each frame found on tx must match the oldest accepted byte
  always @(negedge clk) begin
    int bi;
    int e;
    if (reset) begin
      mon_pos = 0;
    end else if (mon_pos == 0) begin
      if (tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=start_bit required=idle at %0t", $time);
          mon_byte = 8'h00;
        end else begin
          mon_byte = exp_q.pop_front();
        end
        mon_pos = 1;
      end
    end else begin
      bi = mon_pos / CPB;
      if (bi == 0)      e = 0;
      else if (bi == 9) e = 1;
      else              e = int'((mon_byte >> (bi - 1)) & 8'd1);
      check("tx_bit", int'(tx), e);
      mon_pos++;
      if (mon_pos == FRAME) mon_pos = 0;
    end
  end

  task automatic step(input logic se, input logic [7:0] d);
    @(negedge clk);
    check_outputs();
    #1;
    send_enable = se;
    data_in     = d;
    model_edge(se, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    check_outputs();
    #1;
    reset = 1'b1;
    send_enable = 1'b0;
    m_occ = 0;
    m_left = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    #1;
    check("rst_tx",    int'(tx),       1);
    check("rst_busy",  int'(busy),     0);
    check("rst_count", int'(count),    0);
    check("rst_empty", int'(empty),    1);
    check("rst_full",  int'(full),     0);
    check("rst_ovf",   int'(overflow), 0);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      check("rst_tx_hold", int'(tx), 1);
    end
    #1;
    reset = 1'b0;
    model_edge(1'b0, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    do_reset(3);

    // single frame
    step(1'b1, 8'h55);
    idle(45);

    // two back-to-back frames
    step(1'b1, 8'h03);
    step(1'b1, 8'h10);
    idle(85);

    // six consecutive pushes, last one dropped
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    idle(5 * FRAME + 10);

    // push into a full FIFO on the same edge as an end-of-frame pop
    do_reset(2);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i));
    w = 0;
    while (!(m_left == 1 && m_occ == DEPTH) && w < 200) begin
      step(1'b0, 8'h00);
      w++;
    end
    check("wait_stop_end", w < 200 ? 1 : 0, 1);
    step(1'b1, 8'hEE);
    idle(5 * FRAME + 10);

    // reset during data bit 3 with two bytes queued
    do_reset(2);
    step(1'b1, 8'h5A);
    step(1'b1, 8'hC3);
    step(1'b1, 8'h96);
    idle(15);
    check("pre_rst_count", int'(count), 2);
    do_reset(2);
    step(1'b1, 8'hFF);
    idle(45);

    // all-zero byte
    step(1'b1, 8'h00);
    idle(45);

    // random traffic, data_in toggling while send_enable is low
    repeat (800) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        repeat (3) step(1'b1, 8'($urandom));
      end else if (r < 7) begin
        step(1'b1, 8'($urandom));
      end else begin
        step(1'b0, 8'($urandom));
      end
    end

    // drain
    w = 0;
    while ((m_occ > 0 || m_left > 0) && w < 1000) begin
      step(1'b0, 8'($urandom));
      w++;
    end
    check("drain", w < 1000 ? 1 : 0, 1);
    idle(5);
    check("sb_empty", exp_q.size(), 0);
    check("mon_idle", mon_pos, 0);
    check("idle_tx", int'(tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
